// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential 32-bit binary to 8-digit BCD converter.
//
// Double-dabble conversion, one iteration per clock. A conversion accepted
// on one edge delivers its result 32 edges later, with a one-cycle done
// pulse. Values above 99,999,999 saturate to all nines and raise ovf.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high
//   start  in   conversion request, honoured only in IDLE
//   din    in   [31:0] unsigned binary value to convert
//   busy   out  high while a conversion is in progress (registered)
//   done   out  single-cycle pulse, new bcd/ovf valid
//   bcd    out  [31:0] 8 BCD digits, digit 0 in [3:0]
//   ovf    out  last converted value exceeded 99,999,999
//
// Build option
//   BIN2BCD_LZB_EN  when defined, leading zero digits of a non-saturated
//                   result are replaced by 4'hF (digit 0 is never blanked).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last conversion
// CONV  | one double-dabble iteration per cycle, 32 iterations total

module bin2bcd_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] din,
   output logic        busy,
   output logic        done,
   output logic [31:0] bcd,
   output logic        ovf
);

   typedef enum logic {IDLE, CONV} state_t;

   state_t      state, state_nxt;
   logic [31:0] sr;
   logic [39:0] acc;
   logic [4:0]  cnt;

   logic        last_iter;
   logic [39:0] acc_adj;
   logic [39:0] acc_sh;
   logic [31:0] sr_sh;
   logic        ovf_c;
   logic [31:0] res_c;

`ifdef BIN2BCD_LZB_EN
   // Digits above the most-significant nonzero digit become 4'hF.
   function automatic logic [31:0] blank_lz(input logic [31:0] v);
      logic keep;
      blank_lz = v;
      keep     = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         if (v[4*i +: 4] != 4'h0) keep = 1'b1;
         if (!keep) blank_lz[4*i +: 4] = 4'hF;
      end
   endfunction
`endif

   assign last_iter = (cnt == 5'd31);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start)     state_nxt = CONV;
         CONV: if (last_iter) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // One double-dabble step: correct digits >= 5, then shift left by one.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < 10; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   assign acc_sh = {acc_adj[38:0], sr[31]};
   assign sr_sh  = {sr[30:0], 1'b0};

   // Digits 9 and 8 hold everything at or above 100,000,000.
   assign ovf_c = |acc_sh[39:32];

`ifdef BIN2BCD_LZB_EN
   assign res_c = ovf_c ? 32'h9999_9999 : blank_lz(acc_sh[31:0]);
`else
   assign res_c = ovf_c ? 32'h9999_9999 : acc_sh[31:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr   <= '0;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         bcd  <= '0;
         ovf  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sr   <= din;
                  acc  <= '0;
                  cnt  <= '0;
                  busy <= 1'b1;
               end
            end
            CONV: begin
               sr  <= sr_sh;
               acc <= acc_sh;
               cnt <= cnt + 5'd1;
               if (last_iter) begin
                  bcd  <= res_c;
                  ovf  <= ovf_c;
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed conversions checked against literal
// results, plus a per-cycle comparison against an arithmetic reference model.
// Define BIN2BCD_LZB_EN for both bench and design to test leading-zero blanking.

module tb_bin2bcd_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] din;
   logic        busy;
   logic        done;
   logic [31:0] bcd;
   logic        ovf;

   int n_assert = 0;
   int n_fail   = 0;

   bin2bcd_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected display value from plain decimal arithmetic.
   function automatic logic [31:0] ref_bcd(input logic [31:0] v);
      logic [31:0] r;
      logic [3:0]  d [8];
      int unsigned x;
      int          msd;
      if (v > 32'd99_999_999) return 32'h9999_9999;
      x   = v;
      msd = 0;
      for (int i = 0; i < 8; i++) begin
         d[i] = 4'(x % 10);
         x    = x / 10;
         if (d[i] != 4'h0) msd = i;
      end
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = d[i];
`ifdef BIN2BCD_LZB_EN
         if (i > msd) r[4*i +: 4] = 4'hF;
`endif
      end
      return r;
   endfunction

   // Reference model: remaining-cycle countdown plus expected result.
   int          m_rem;
   logic        m_busy, m_done, m_ovf;
   logic [31:0] m_bcd, m_val;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem  = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_ovf  = 1'b0;
         m_bcd  = '0;
         m_val  = '0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_bcd  = ref_bcd(m_val);
               m_ovf  = (m_val > 32'd99_999_999);
            end
         end else if (start) begin
            m_val  = din;
            m_rem  = 32;
            m_busy = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_busy", {31'd0, busy}, {31'd0, m_busy});
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_bcd",  bcd,           m_bcd);
      check("model_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
   end

   // Caller is at a negedge; start is accepted on the following posedge.
   task automatic pulse_start(input logic [31:0] v);
      start = 1'b1;
      din   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      din   = $urandom;
   endtask

   // Counts posedges until done is seen; returns at that negedge.
   task automatic wait_done(output int edges);
      edges = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         edges = e;
         @(negedge clk);
         if (done) return;
      end
      edges = 99;
   endtask

   task automatic convert(input string name, input logic [31:0] v,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
      int edges;
      @(negedge clk);
      pulse_start(v);
      wait_done(edges);
      check({name, "_latency"}, 32'(edges), 32'd32);
      check({name, "_bcd"}, bcd, exp_bcd);
      check({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
   endtask

   initial begin
      int edges, ndone, first, busy_drop;
      reset = 1'b1;
      start = 1'b0;
      din   = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_bcd",  bcd, 32'h0);
      check("reset_ovf",  {31'd0, ovf}, 32'd0);
      reset = 1'b0;

`ifdef BIN2BCD_LZB_EN
      convert("zero",  32'd0,          32'hFFFF_FFF0, 1'b0);
      convert("d42",   32'd42,         32'hFFFF_FF42, 1'b0);
`else
      convert("zero",  32'd0,          32'h0000_0000, 1'b0);
      convert("d42",   32'd42,         32'h0000_0042, 1'b0);
`endif
      convert("d12345678", 32'h00BC_614E, 32'h1234_5678, 1'b0);
      convert("max_ok",    32'h05F5_E0FF, 32'h9999_9999, 1'b0);
      convert("ovf_min",   32'h05F5_E100, 32'h9999_9999, 1'b1);
      convert("ovf_max",   32'hFFFF_FFFF, 32'h9999_9999, 1'b1);

      // start during a conversion is ignored
      @(negedge clk);
      pulse_start(32'd5);
      ndone = 0; first = -1; busy_drop = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 9) begin
            start = 1'b1;
            din   = 32'd7;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            if (first < 0) first = e;
         end
         if (e < 32 && !busy) busy_drop++;
      end
      start = 1'b0;
      check("ignore_ndone", 32'(ndone), 32'd1);
      check("ignore_edge",  32'(first), 32'd32);
      check("ignore_busy",  32'(busy_drop), 32'd0);
`ifdef BIN2BCD_LZB_EN
      check("ignore_bcd", bcd, 32'hFFFF_FFF5);
`else
      check("ignore_bcd", bcd, 32'h0000_0005);
`endif

      // reset mid-conversion aborts without done
      @(negedge clk);
      pulse_start(32'd12_345_678);
      ndone = 0;
      repeat (16) begin
         @(posedge clk);
         #1 if (done) ndone++;
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_bcd",  bcd, 32'h0);
      check("abort_ovf",  {31'd0, ovf}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_ndone", 32'(ndone), 32'd0);
      reset = 1'b0;
      pulse_start(32'd321);
      wait_done(edges);
      check("after_reset_latency", 32'(edges), 32'd32);
`ifdef BIN2BCD_LZB_EN
      check("after_reset_bcd", bcd, 32'hFFFF_F321);
`else
      check("after_reset_bcd", bcd, 32'h0000_0321);
`endif

      // start in the done cycle is accepted
      convert("pre_b2b", 32'd88, ref_bcd(32'd88), 1'b0);
      check("b2b_done_high", {31'd0, done}, 32'd1);
      pulse_start(32'd9);
      check("b2b_accept_busy", {31'd0, busy}, 32'd1);
      wait_done(edges);
      check("b2b_latency", 32'(edges), 32'd32);
`ifdef BIN2BCD_LZB_EN
      check("b2b_bcd", bcd, 32'hFFFF_FFF9);
`else
      check("b2b_bcd", bcd, 32'h0000_0009);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
